// File: rtl/risc_v_pipe_pkg.sv
// Shared definitions for the core's inter-stage pipeline registers.
// Holds the control-field layout and the default control/payload widths,
// which are derived from the architectural register and PC widths.
package risc_v_pipe_pkg;

   localparam int REG_WIDTH      = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int PC_WIDTH       = 32;
   localparam int OPCODE_WIDTH   = 7;
   // Immediate as carried between stages (sign extension happens in EX).
   localparam int IMM_WIDTH      = 16;

   // Control field layout (bit offsets / widths).
   localparam int CTRL_REG_WE      = 0;
   localparam int CTRL_ALU_SEL_LSB = 1;
   localparam int CTRL_ALU_SEL_W   = 3;
   localparam int CTRL_MEM_WE      = 4;
   localparam int CTRL_ASEL        = 5;
   localparam int CTRL_BSEL        = 6;
   localparam int CTRL_WB_SEL_LSB  = 7;
   localparam int CTRL_WB_SEL_W    = 2;
   localparam int CTRL_PC_SEL      = 9;
   localparam int CTRL_SPARE_LSB   = 10;
   localparam int CTRL_SPARE_W     = 2;

   localparam int DEF_CTRL_WIDTH = CTRL_SPARE_LSB + CTRL_SPARE_W;   // 12

   // pc_next + opcode + rs1/rs2/rd + two operands + immediate = 134
   localparam int DEF_DATA_WIDTH = PC_WIDTH + OPCODE_WIDTH + 3*REG_ADDR_WIDTH
                                 + 2*REG_WIDTH + IMM_WIDTH;

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the elastic pipe: valid, control and payload flops.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   load              slot may take its upstream value this cycle
//   flush             kill stored entry (v,c cleared; payload kept)
//   d_en              payload write enable when loading
//   up_v, up_c, up_d  upstream valid / control / payload
//   v, c, d           stored valid / control / payload
module pipe_slot #(
   parameter int CTRL_WIDTH = 12,
   parameter int DATA_WIDTH = 134
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  flush,
   input  logic                  d_en,
   input  logic                  up_v,
   input  logic [CTRL_WIDTH-1:0] up_c,
   input  logic [DATA_WIDTH-1:0] up_d,
   output logic                  v,
   output logic [CTRL_WIDTH-1:0] c,
   output logic [DATA_WIDTH-1:0] d
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v <= 1'b0;
         c <= '0;
         d <= '0;
      end else if (flush) begin
         // Payload deliberately untouched: only v/c matter after a kill.
         v <= 1'b0;
         c <= '0;
      end else if (load) begin
         v <= up_v;
         c <= up_v ? up_c : '0;
         if (d_en) d <= up_d;
      end
   end

   // An empty slot must never present live control bits.
   a_empty_ctrl_zero: assert property (@(posedge clk) disable iff (!reset_n)
      !v |-> (c == '0));

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic inter-stage pipeline register (valid/ready) with bubble insertion
// and whole-pipe flush. STAGES slots in series; slot 0 is the input side.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   in_valid/in_ready/in_ctrl/in_data  upstream handshake and fields
//   ctr_sel                            0 = store control as zero (bubble)
//   flush                              kill every stored entry
//   out_valid/out_ready/out_ctrl/out_data  downstream handshake and fields
//   occupancy                          number of valid slots
module elastic_pipe_reg
   import risc_v_pipe_pkg::*;
#(
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int STAGES     = 1,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  ctr_sel,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  occupancy
);

   logic [STAGES-1:0]                 v, rdy, up_v, d_en;
   logic [STAGES-1:0][CTRL_WIDTH-1:0] c, up_c;
   logic [STAGES-1:0][DATA_WIDTH-1:0] d, up_d;
   logic                              rdy_acc;
   logic                              accept, handoff;

   // Ready chain: a slot can load if it is empty or everything downstream
   // of it can move. Accumulated from the output side to avoid a
   // self-referencing vector.
   always_comb begin
      rdy_acc = out_ready;
      rdy     = '0;
      for (int i = STAGES-1; i >= 0; i--) begin
         rdy_acc = rdy_acc | ~v[i];
         rdy[i]  = rdy_acc;
      end
   end

   assign in_ready = rdy[0] & ~flush;

   for (genvar i = 0; i < STAGES; i++) begin : g_slot
      if (i == 0) begin : g_head
         assign up_v[i] = in_valid;
         assign up_c[i] = (in_valid & ctr_sel) ? in_ctrl : '0;
         assign up_d[i] = in_data;
         assign d_en[i] = in_valid;      // hold payload when nothing arrives
      end else begin : g_body
         assign up_v[i] = v[i-1];
         assign up_c[i] = c[i-1];
         assign up_d[i] = d[i-1];
         assign d_en[i] = 1'b1;
      end

      pipe_slot #(
         .CTRL_WIDTH (CTRL_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .clk     (clk),
         .reset_n (reset_n),
         .load    (rdy[i]),
         .flush   (flush),
         .d_en    (d_en[i]),
         .up_v    (up_v[i]),
         .up_c    (up_c[i]),
         .up_d    (up_d[i]),
         .v       (v[i]),
         .c       (c[i]),
         .d       (d[i])
      );
   end

   assign out_valid = v[STAGES-1];
   assign out_ctrl  = c[STAGES-1];
   assign out_data  = d[STAGES-1];

   assign accept  = in_valid & in_ready;
   assign handoff = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         occupancy <= '0;
      else if (flush)
         occupancy <= '0;
      else
         occupancy <= occupancy + CNT_WIDTH'(accept) - CNT_WIDTH'(handoff);
   end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench: three instances (STAGES=1,2,3) share the input stimulus;
// each scenario resets all of them and checks the instance it targets.
module tb_elastic_pipe_reg;

   localparam int CW = 12;
   localparam int DW = 134;
   localparam int NW = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, ctr_sel, flush, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          r1, r2, r3, v1, v2, v3;
   logic [CW-1:0] c1, c2, c3;
   logic [DW-1:0] d1, d2, d3;
   logic [NW-1:0] n1, n2, n3;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(1), .CNT_WIDTH(NW)) u1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r1),
      .in_ctrl(in_ctrl), .in_data(in_data), .ctr_sel(ctr_sel), .flush(flush),
      .out_valid(v1), .out_ready(out_ready), .out_ctrl(c1), .out_data(d1),
      .occupancy(n1));

   elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(2), .CNT_WIDTH(NW)) u2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r2),
      .in_ctrl(in_ctrl), .in_data(in_data), .ctr_sel(ctr_sel), .flush(flush),
      .out_valid(v2), .out_ready(out_ready), .out_ctrl(c2), .out_data(d2),
      .occupancy(n2));

   elastic_pipe_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(3), .CNT_WIDTH(NW)) u3 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r3),
      .in_ctrl(in_ctrl), .in_data(in_data), .ctr_sel(ctr_sel), .flush(flush),
      .out_valid(v3), .out_ready(out_ready), .out_ctrl(c3), .out_data(d3),
      .occupancy(n3));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      ctr_sel   = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_ctrl   = '0;
      in_data   = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      idle_inputs();
      do_reset();

      // ---- reset state ----
      chk("rst_valid", v1, 0);
      chk("rst_ctrl",  c1, 0);
      chk("rst_data",  d1, 0);
      chk("rst_occ",   n1, 0);
      chk("rst_ready", r1, 1);
      chk("rst_occ3",  n3, 0);

      // ---- 1: single entry through STAGES=1 ----
      in_valid = 1'b1; in_ctrl = 12'h0A5; in_data = 'h1234;
      tick();
      chk("t1_valid", v1, 1);
      chk("t1_ctrl",  c1, 12'h0A5);
      chk("t1_data",  d1, 'h1234);
      chk("t1_occ",   n1, 1);
      in_valid = 1'b0;
      tick();
      chk("t1_drain_valid", v1, 0);
      chk("t1_drain_ctrl",  c1, 0);
      chk("t1_drain_occ",   n1, 0);
      chk("t1_data_held",   d1, 'h1234);

      // ---- 2: stream 5 entries through STAGES=3 ----
      do_reset();
      for (int t = 0; t < 8; t++) begin
         in_valid = (t < 5);
         in_ctrl  = (t < 5) ? CW'(t + 1) : '0;
         in_data  = (t < 5) ? DW'(16 * (t + 1)) : '0;
         #1;
         if (t < 5) chk("t2_in_ready", r3, 1);
         tick();
         // entry accepted at edge t is on the output after edge t+2
         if (t >= 2 && t <= 6) begin
            chk("t2_valid", v3, 1);
            chk("t2_ctrl",  c3, t - 1);
            chk("t2_data",  d3, 16 * (t - 1));
         end else begin
            chk("t2_idle_valid", v3, 0);
            chk("t2_idle_ctrl",  c3, 0);
         end
      end

      // ---- 3: backpressure on STAGES=2 ----
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 12'd7; in_data = 'h70;
      tick();
      in_ctrl = 12'd8; in_data = 'h80;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t3_occ",      n2, 2);
         chk("t3_in_ready", r2, 0);
         chk("t3_valid",    v2, 1);
         chk("t3_ctrl",     c2, 7);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t3_rel_ctrl0", c2, 7);
      tick();
      chk("t3_rel_valid1", v2, 1);
      chk("t3_rel_ctrl1",  c2, 8);
      chk("t3_rel_data1",  d2, 'h80);
      chk("t3_rel_occ1",   n2, 1);
      tick();
      chk("t3_empty_valid", v2, 0);
      chk("t3_empty_occ",   n2, 0);

      // ---- 4: bubble on STAGES=1 ----
      do_reset();
      in_valid = 1'b1; ctr_sel = 1'b0; in_ctrl = 12'hFFF; in_data = 'hBEEF;
      tick();
      chk("t4_valid", v1, 1);
      chk("t4_ctrl",  c1, 0);
      chk("t4_data",  d1, 'hBEEF);
      chk("t4_occ",   n1, 1);
      in_valid = 1'b0; ctr_sel = 1'b1;

      // ---- 5: flush a full STAGES=3 pipe ----
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1; in_ctrl = CW'(k); in_data = DW'(k);
         tick();
      end
      chk("t5_full_occ", n3, 3);
      flush = 1'b1; in_valid = 1'b1; in_ctrl = 12'h055; in_data = 'h55;
      #1;
      chk("t5_in_ready", r3, 0);
      chk("t5_out_valid_during", v3, 1);
      chk("t5_out_ctrl_during",  c3, 1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("t5_occ",   n3, 0);
      chk("t5_valid", v3, 0);
      chk("t5_ctrl",  c3, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t5_no_ghost", v3, 0);
      end

      // ---- 6: async reset mid-stream on STAGES=2 ----
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 12'h011; in_data = 'hAA;
      tick();
      in_ctrl = 12'h022; in_data = 'hBB;
      tick();
      in_valid = 1'b0;
      chk("t6_pre_occ", n2, 2);
      #1;
      reset_n = 1'b0;
      #1;   // still well before the next rising edge
      chk("t6_valid", v2, 0);
      chk("t6_ctrl",  c2, 0);
      chk("t6_data",  d2, 0);
      chk("t6_occ",   n2, 0);
      tick();
      reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
